// File: rtl/mag_pkg.sv
// mag_pkg
// Shared defaults and state encoding for the magnitude square-root block.
//   MAG_IN_W  : width of the squared-magnitude (power) word
//   MAG_OUT_W : width of the integer root, ceil(MAG_IN_W/2)
//   state_t   : sequencer states used by mag_sqrt
package mag_pkg;

  // Root width needed to hold floor(sqrt(x)) for an unsigned w-bit x.
  function automatic int root_w(input int w);
    return (w + 1) / 2;
  endfunction

  localparam int MAG_IN_W  = 55;
  localparam int MAG_OUT_W = root_w(MAG_IN_W);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mag_sqrt.sv
// mag_sqrt
// Sequential integer square root of an unsigned power word. One root bit is
// resolved per clock, MSB first, using the digit-by-digit restoring method.
// The result and its remainder are held until the consumer accepts them.
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous reset, active high
//   clr        : synchronous abort/flush, overrides handshakes
//   in_valid   : in_data qualifier
//   in_ready   : high only while idle
//   in_data    : unsigned power word x (IN_W bits)
//   out_valid  : result qualifier, high only while holding a result
//   out_ready  : downstream accept
//   out_root   : floor(sqrt(x)) (OUT_W bits)
//   out_rem    : x - out_root^2 (OUT_W+1 bits)
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for a word; in_ready=1
// ST_CALC | resolving one root bit per edge, counter OUT_W-1 down to 0
// ST_DONE | result held on out_root/out_rem; out_valid=1
module mag_sqrt
  import mag_pkg::*;
#(
  parameter int IN_W  = MAG_IN_W,
  parameter int OUT_W = MAG_OUT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_root,
  output logic [OUT_W:0]   out_rem
);

  // x is zero-extended to an even width so bits pair cleanly into digits.
  localparam int X_W   = 2 * OUT_W;
  // The remainder never exceeds 2*root (< 2^(OUT_W+1)); after the two-bit
  // shift-in it needs OUT_W+3 bits, which also covers x = 2^IN_W-1.
  localparam int REM_W = OUT_W + 3;
  localparam int CNT_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  state_t             state;
  logic [X_W-1:0]     x_q;
  logic [OUT_W-1:0]   root_q;
  logic [REM_W-1:0]   rem_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [REM_W-1:0]   rem_sh;
  logic [REM_W-1:0]   trial;
  logic               take;
  logic [REM_W-1:0]   rem_nxt;
  logic [OUT_W-1:0]   root_nxt;

  // One restoring step: bring down the next digit pair, try subtracting
  // (4*root + 1); a non-negative result means the next root bit is 1.
  always_comb begin
    rem_sh   = '0;
    trial    = '0;
    take     = 1'b0;
    rem_nxt  = '0;
    root_nxt = '0;

    rem_sh   = (rem_q << 2) | REM_W'(x_q[X_W-1 -: 2]);
    trial    = REM_W'({root_q, 2'b01});
    take     = (rem_sh >= trial);
    rem_nxt  = take ? (rem_sh - trial) : rem_sh;
    root_nxt = {root_q[OUT_W-2:0], take};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      x_q       <= '0;
      root_q    <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
    end else if (clr) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      x_q       <= '0;
      root_q    <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            x_q      <= X_W'(in_data);
            root_q   <= '0;
            rem_q    <= '0;
            cnt_q    <= CNT_W'(OUT_W - 1);
            state    <= ST_CALC;
            in_ready <= 1'b0;
          end
        end

        ST_CALC: begin
          x_q    <= {x_q[X_W-3:0], 2'b00};
          root_q <= root_nxt;
          rem_q  <= rem_nxt;
          if (cnt_q == '0) begin
            state     <= ST_DONE;
            out_valid <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        ST_DONE: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end

        default: begin
          state     <= ST_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_root = root_q;
  assign out_rem  = rem_q[OUT_W:0];

endmodule

// File: tb/tb_mag_sqrt.sv
// tb_mag_sqrt
// Directed checks of mag_sqrt with hand-computed results, followed by a short
// randomized handshake run checked against the floor-sqrt definition.
module tb_mag_sqrt;

  localparam int IN_W  = 55;
  localparam int OUT_W = 28;

  logic             clk;
  logic             rst;
  logic             clr;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_root;
  logic [OUT_W:0]   out_rem;

  int checks = 0;
  int errors = 0;

  mag_sqrt #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_root  (out_root),
    .out_rem   (out_rem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Accept x, wait for the result with a cycle budget, check latency/value,
  // then confirm the one-cycle release back to idle (out_ready assumed 1).
  task automatic run_one(input string tag, input logic [IN_W-1:0] x,
                         input logic [63:0] er, input logic [63:0] ee);
    int n;
    @(negedge clk);
    check({tag, "_rdy"}, 64'(in_ready), 64'd1);
    in_data  = x;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = IN_W'({$urandom, $urandom});
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      in_data = IN_W'({$urandom, $urandom});
      n++;
    end
    check({tag, "_lat"}, 64'(n), 64'd28);
    check({tag, "_root"}, 64'(out_root), er);
    check({tag, "_rem"}, 64'(out_rem), ee);
    check({tag, "_busy"}, 64'(in_ready), 64'd0);
    @(negedge clk);
    check({tag, "_vld_drop"}, 64'(out_valid), 64'd0);
    check({tag, "_rdy_back"}, 64'(in_ready), 64'd1);
  endtask

  logic [63:0] q[$];
  logic [63:0] xs, rt, rm;
  int n, seen, issued, popped, cyc;

  initial begin
    rst       = 1'b1;
    clr       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;

    #12;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_root", 64'(out_root), 64'd0);
    check("rst_rem", 64'(out_rem), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_one("x0", 55'd0, 64'd0, 64'd0);
    run_one("x99", 55'd99, 64'd9, 64'd18);
    run_one("x1e6", 55'd1000000, 64'd1000, 64'd0);
    run_one("x2p53", 55'h20000000000000, 64'd94906265, 64'd118490767);
    run_one("xmax", 55'h7FFFFFFFFFFFFF, 64'd189812531, 64'd94338006);
    run_one("x3", 55'd3, 64'd1, 64'd2);

    // Hold in DONE with in_valid high and in_data changing throughout.
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 55'd12345678;
    @(negedge clk);
    n = 0;
    while (!out_valid && n < 40) begin
      in_data = IN_W'({$urandom, $urandom});
      @(negedge clk);
      n++;
    end
    check("hold_lat", 64'(n), 64'd28);
    for (int i = 0; i < 10; i++) begin
      in_data = IN_W'({$urandom, $urandom});
      @(negedge clk);
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_ready", 64'(in_ready), 64'd0);
      check("hold_root", 64'(out_root), 64'd3513);
      check("hold_rem", 64'(out_rem), 64'd4509);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("hold_release_vld", 64'(out_valid), 64'd0);
    check("hold_release_rdy", 64'(in_ready), 64'd1);

    // Reset pulse at CALC cycle 10.
    in_data  = 55'd99;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rstmid_rdy", 64'(in_ready), 64'd1);
    check("rstmid_vld", 64'(out_valid), 64'd0);
    check("rstmid_root", 64'(out_root), 64'd0);
    check("rstmid_rem", 64'(out_rem), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("rstmid_no_out", 64'(seen), 64'd0);
    run_one("rst_x16", 55'd16, 64'd4, 64'd0);

    // Flush at CALC cycle 20.
    in_data  = 55'd1000000;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (20) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_rdy", 64'(in_ready), 64'd1);
    check("clr_vld", 64'(out_valid), 64'd0);
    check("clr_root", 64'(out_root), 64'd0);
    check("clr_rem", 64'(out_rem), 64'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("clr_no_out", 64'(seen), 64'd0);
    run_one("clr_x16", 55'd16, 64'd4, 64'd0);

    // Reset while a result is waiting in DONE.
    out_ready = 1'b0;
    in_data   = 55'd99;
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("rstdone_lat", 64'(n), 64'd28);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("rstdone_no_out", 64'(seen), 64'd0);
    check("rstdone_rdy", 64'(in_ready), 64'd1);

    // Randomized handshakes; each result checked against the definition of
    // floor(sqrt(x)) and matched in order to the accepted words.
    issued = 0;
    popped = 0;
    cyc    = 0;
    while (popped < 150 && cyc < 30000) begin
      @(negedge clk);
      cyc++;
      in_valid  = (issued < 150) && ($urandom_range(0, 3) != 0);
      in_data   = IN_W'({$urandom, $urandom} >> $urandom_range(0, 54));
      out_ready = ($urandom_range(0, 2) != 0);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("rnd_extra_result", 64'd1, 64'(q.size()));
        end else begin
          xs = q.pop_front();
          rt = 64'(out_root);
          rm = 64'(out_rem);
          check("rnd_root_lo", 64'(rt * rt <= xs), 64'd1);
          check("rnd_root_hi", 64'(xs < (rt + 1) * (rt + 1)), 64'd1);
          check("rnd_rem", rm, xs - rt * rt);
        end
        popped++;
      end
      if (in_valid && in_ready) begin
        q.push_back(64'(in_data));
        issued++;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("rnd_results", 64'(popped), 64'd150);
    check("rnd_queue_empty", 64'(q.size()), 64'd0);
    repeat (3) @(negedge clk);
    check("rnd_idle_vld", 64'(out_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mag_sqrt.md
MAG_SQRT -- requirements
Module: mag_sqrt

Interface
REQ-001 Parameter IN_W, default 55, SHALL set the power-word input width; it matches the squared-magnitude sum produced upstream.
REQ-002 Parameter OUT_W, default 28 (= ceil(IN_W/2)), SHALL set the root width.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 clr  input  1  SHALL be a synchronous abort/flush.
REQ-006 in_valid  input  1  SHALL qualify in_data.
REQ-007 in_ready  output  1  SHALL indicate the block can accept a word.
REQ-008 in_data  input  IN_W  SHALL carry the unsigned power word x.
REQ-009 out_valid  output  1  SHALL qualify out_root and out_rem.
REQ-010 out_ready  input  1  SHALL be the downstream accept.
REQ-011 out_root  output  OUT_W  SHALL carry floor(sqrt(x)).
REQ-012 out_rem  output  OUT_W+1  SHALL carry x - out_root^2.

Function
REQ-013 States SHALL be IDLE, CALC and DONE; in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-014 IDLE->CALC SHALL occur on an edge with in_valid=1 and in_ready=1 (accept edge): capture x, clear root/remainder, set bit counter to OUT_W-1.
REQ-015 CALC SHALL resolve one root bit per cycle, MSB first, by digit-by-digit restoring or non-restoring method, decrementing the counter each edge.
REQ-016 CALC->DONE SHALL occur on the edge processing counter 0, so out_valid rises on the OUT_W-th edge after the accept edge (28 with defaults).
REQ-017 In DONE, out_root/out_rem SHALL hold stable until an edge with out_ready=1, which SHALL go to IDLE (out_valid=0, in_ready=1 next cycle).
REQ-018 No accept SHALL occur in DONE even if in_valid=1; throughput SHALL be one result per OUT_W+2 cycles minimum.
REQ-019 in_data changes while not accepted SHALL have no effect; in_valid=1 during CALC SHALL be ignored, not queued.
REQ-020 Results SHALL be exact for every x in [0, 2^IN_W-1]: out_root^2 <= x < (out_root+1)^2, with out_rem <= 2*out_root.
REQ-021 Internal remainder arithmetic SHALL be at least OUT_W+2 bits wide so no intermediate overflows at x = 2^IN_W-1.
REQ-022 clr=1 SHALL, on that edge and with priority over all handshakes, return to IDLE, drop out_valid and discard any capture in progress; outputs SHALL be zero afterwards.

Reset
REQ-023 While rst=1, state SHALL be IDLE, in_ready=1, out_valid=0, and out_root, out_rem, counter and all datapath registers SHALL be 0.
REQ-024 Reset asserted mid-CALC or in DONE SHALL discard the operation with no output pulse after release.
REQ-025 First accept after rst deasserts SHALL be possible on the first rising edge with in_valid=1.

Structure
REQ-026 A shared package mag_pkg SHALL hold IN_W/OUT_W defaults and the state enumeration; mag_sqrt SHALL import it.
REQ-027 mag_sqrt SHALL be a single module with no sub-module; the per-bit step stays inline combinational logic.

Verification
REQ-028 x=0, out_ready=1 -> out_root=0, out_rem=0, out_valid high exactly 28 edges after accept, for one cycle.
REQ-029 x=99 then x=1000000 -> (9, 18) then (1000, 0); the second accept occurs no earlier than 2 cycles after the first out_valid.
REQ-030 x=2^53 -> out_root=94906265, out_rem=118490767; x=2^55-1 -> out_root=189812531, out_rem checked by reference model.
REQ-031 out_ready=0 for 10 cycles in DONE with in_valid=1 and changing in_data -> outputs stable, in_ready=0, no new accept; result released on out_ready=1.
REQ-032 rst pulse at CALC cycle 10, and separately clr at cycle 20 -> no out_valid, in_ready=1 next cycle, following x=16 gives (4, 0).
REQ-033 10^5 random x against a floor-sqrt model with random in_valid/out_ready -> zero mismatches, no lost or duplicated results.
